sram_rw_port_ctrl: RTL and testbench
====================================

Name: sram_rw_port_ctrl

Overview:
- Requester-side controller for the single-port 512x152 masked SRAM macros: 9-bit address, 8 mask lanes of 19 bits, 1-cycle registered read.
- Accepts read/write commands on a valid/ready request channel and drives the macro's RW0 port.
- Collects read data into a response queue so the consumer can back-pressure without losing reads.
- Optional power-on scrub zeroes the whole array before the first command is accepted.

Parameters:
- ADDR_W, 9, address width; array depth = 2^ADDR_W.
- LANES, 8, write-mask lanes.
- LANE_W, 19, bits per lane; DATA_W = LANES*LANE_W = 152.
- QUEUE_DEPTH, 3, response queue entries. Minimum 2; 3 gives full read throughput.

Ports:
- clock  in  1  sole clock; also clocks the SRAM macro.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  command valid.
- req_ready  out  1  command accepted when valid&&ready.
- req_write  in  1  1=write, 0=read.
- req_addr  in  ADDR_W  command address.
- req_wmask  in  LANES  per-lane write enable.
- req_wdata  in  DATA_W  write data.
- resp_valid  out  1  read data valid.
- resp_ready  in  1  consumer accepts read data.
- resp_data  out  DATA_W  read data, in request order.
- init_done  out  1  controller accepting commands.
- mem_addr  out  ADDR_W  to RW0_addr.
- mem_en  out  1  to RW0_en.
- mem_wmode  out  1  to RW0_wmode.
- mem_wmask  out  LANES  to RW0_wmask.
- mem_wdata  out  DATA_W  to RW0_wdata.
- mem_rdata  in  DATA_W  from RW0_rdata; valid the cycle after a read enable.

Behaviour:
- Reset values:
  - resp_valid=0, queue empty, rd_inflight=0.
  - init_done=1, or 0 when SRAM_INIT_EN is defined.
  - mem_en=0, mem_wmode=0.
- Ready condition:
  - Writes: req_ready = init_done.
  - Reads: req_ready = init_done && (occupancy + rd_inflight) < QUEUE_DEPTH.
  - req_ready is a function of registered state only. It never depends on resp_ready or on req_valid/req_write.
- Command issue (fire cycle T):
  - mem_en = fire, combinational.
  - mem_wmode = req_write; mem_addr/mem_wmask/mem_wdata pass through combinationally.
  - When not firing, mem_en=0 and the other mem outputs are don't-care (drive request inputs).
- Read path:
  - rd_inflight <= read fire at T.
  - At T+1, if rd_inflight, mem_rdata is pushed into the queue.
  - resp_valid is asserted at T+2 at the earliest. Latency is fixed at 2 cycles when the queue is empty.
- Queue:
  - FIFO, registered output; resp_data is driven from the head entry.
  - Pop when resp_valid && resp_ready.
  - Push and pop in the same cycle are allowed at any occupancy, including full; occupancy is then unchanged.
  - Overflow cannot occur because of the space reservation.
- Writes:
  - Produce no response.
  - A read issued the cycle after a write to the same address returns the new data (macro semantics).
  - Lanes with mask=0 keep their old value.
  - A write with an all-zero mask is still issued.
- Ordering: responses are returned strictly in read-accept order.
- Throughput: with QUEUE_DEPTH>=3 and resp_ready held 1, one read is accepted per cycle indefinitely.
- Reset mid-operation: in-flight read and queued data are discarded; no response is produced for them.

Optional Feature:
- Macro: SRAM_INIT_EN.
- Defined:
  - FSM with states SCRUB and RUN; reset enters SCRUB with scrub_addr=0.
  - In SCRUB, each cycle: mem_en=1, mem_wmode=1, mem_wmask=all-ones, mem_wdata=0, mem_addr=scrub_addr; scrub_addr increments.
  - After writing address 2^ADDR_W-1 (512 cycles), move to RUN and set init_done=1 the following cycle.
  - req_ready=0 throughout SCRUB.
- Not defined: no FSM; the controller is in RUN from reset and init_done is constant 1 after reset.

Test Plan:
- Write addr 0x05, mask 0xFF, data D1; next cycle read 0x05 -> resp_valid 2 cycles after the read fire, resp_data=D1.
- Write 0x10 with D1 mask 0xFF, then D2 mask 0x0F; read 0x10 -> lanes 0-3 = D2, lanes 4-7 = D1.
- resp_ready=0, issue 4 back-to-back reads -> 3 accepted, req_ready=0 on the 4th. Raise resp_ready -> 4th accepted; all 4 responses in order.
- resp_ready=1, 100 consecutive reads of addr 0..99 -> req_ready never drops, 100 responses in order, no gaps.
- Assert reset_n=0 with 2 reads queued and 1 in flight -> resp_valid=0 next cycle. After release, no stale response appears.
- SRAM_INIT_EN defined: after reset, req_ready=0 and init_done=0 for 512 cycles, mem_wdata=0 on every scrub write. Then read any address (e.g. 0x1FF) -> 0.

Source files
------------

// File: rtl/sram_rw_port_ctrl.sv
// -----------------------------------------------------------------------------
// sram_rw_port_ctrl
//
// Requester-side controller for a single-port 512x152 masked SRAM macro with a
// 1-cycle registered read. It takes read/write commands on a valid/ready
// request channel, drives the macro's RW0 port, and returns read data through
// a small response FIFO so the consumer can back-pressure without losing reads.
//
// Build option:
//   SRAM_INIT_EN  when defined, a power-on scrub writes zero to every address
//                 before the first command is accepted (SCRUB -> RUN FSM).
//                 When undefined there is no FSM and the controller starts in
//                 RUN straight out of reset.
//
// Ports:
//   clock, reset_n        sole clock (also clocks the macro); async active-low reset
//   req_valid/req_ready   command handshake
//   req_write             1 = write, 0 = read
//   req_addr              command address
//   req_wmask             per-lane write enable
//   req_wdata             write data
//   resp_valid/resp_ready read response handshake
//   resp_data             read data, in read-accept order
//   init_done             controller is accepting commands
//   mem_addr/en/wmode/wmask/wdata   to the macro's RW0 port
//   mem_rdata             from RW0_rdata, valid the cycle after a read enable
//
// Handshake rule (both channels): a transfer happens on a rising clock edge
// where valid && ready are both 1. A source holds valid and its payload stable
// until the transfer. req_ready and resp_valid are functions of registered
// state only; neither looks at the other side's valid/ready or at req_write.
// -----------------------------------------------------------------------------
module sram_rw_port_ctrl #(
    parameter int ADDR_W      = 9,
    parameter int LANES       = 8,
    parameter int LANE_W      = 19,
    parameter int QUEUE_DEPTH = 3,
    localparam int DATA_W     = LANES * LANE_W
) (
    input  logic              clock,
    input  logic              reset_n,

    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LANES-1:0]  req_wmask,
    input  logic [DATA_W-1:0] req_wdata,

    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,

    output logic              init_done,

    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_en,
    output logic              mem_wmode,
    output logic [LANES-1:0]  mem_wmask,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);

    // ------------------------------------------------------------------
    // Run / scrub control
    // ------------------------------------------------------------------
    logic              run;
    logic              scrub_active;
    logic [ADDR_W-1:0] scrub_addr;

`ifdef SRAM_INIT_EN
    typedef enum logic {
        SCRUB = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= SCRUB;
            scrub_addr <= '0;
        end else begin
            state <= state_next;
            if (state == SCRUB) begin
                scrub_addr <= scrub_addr + 1'b1;
            end
        end
    end

    // Leave SCRUB after the cycle that writes the last address; the address
    // counter wraps back to zero on the same edge.
    always_comb begin
        state_next = state;
        if ((state == SCRUB) && (scrub_addr == '1)) begin
            state_next = RUN;
        end
    end

    assign run          = (state == RUN);
    assign scrub_active = (state == SCRUB);
`else
    assign run          = 1'b1;
    assign scrub_active = 1'b0;
    assign scrub_addr   = '0;
`endif

    assign init_done = run;

    // ------------------------------------------------------------------
    // Space reservation and command issue
    // ------------------------------------------------------------------
    logic              rd_inflight;
    logic [CNT_W-1:0]  q_count;
    logic [CNT_W:0]    reserved;
    logic              space_ok;
    logic              fire;
    logic              rd_fire;

    // A read needs a queue slot for its data one cycle after issue. Counting
    // the in-flight read against the depth guarantees that slot exists, so
    // the queue can never overflow. Writes share the same ready so that
    // req_ready stays independent of req_write; this only holds a write back
    // while the queue is completely reserved.
    assign reserved  = {1'b0, q_count} + {{CNT_W{1'b0}}, rd_inflight};
    assign space_ok  = (reserved < (CNT_W + 1)'(QUEUE_DEPTH));
    assign req_ready = run && space_ok;

    assign fire    = req_valid && req_ready;
    assign rd_fire = fire && !req_write;

    // The macro port is driven straight from the request inputs on the fire
    // cycle; during scrub the scrub writer owns the port.
    always_comb begin
        mem_en    = fire;
        mem_wmode = fire && req_write;
        mem_addr  = req_addr;
        mem_wmask = req_wmask;
        mem_wdata = req_wdata;
        if (scrub_active) begin
            mem_en    = 1'b1;
            mem_wmode = 1'b1;
            mem_addr  = scrub_addr;
            mem_wmask = '1;
            mem_wdata = '0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_inflight <= 1'b0;
        end else begin
            rd_inflight <= rd_fire;
        end
    end

    // ------------------------------------------------------------------
    // Response queue
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] q_mem [QUEUE_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              push;
    logic              pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(QUEUE_DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    // Read data is captured the cycle after its read enable.
    assign push = rd_inflight;
    assign pop  = resp_valid && resp_ready;

    assign resp_valid = (q_count != '0);
    assign resp_data  = q_mem[rd_ptr];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            q_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            // Simultaneous push and pop leaves the occupancy unchanged, even
            // when full: the head is read out on the same edge the new entry
            // lands in the slot that wr_ptr addresses.
            case ({push, pop})
                2'b10:   q_count <= q_count + CNT_W'(1);
                2'b01:   q_count <= q_count - CNT_W'(1);
                default: q_count <= q_count;
            endcase
        end
    end

    // Payload storage carries no reset; stale entries are unreachable once
    // the pointers and count are cleared.
    always_ff @(posedge clock) begin
        if (push) begin
            q_mem[wr_ptr] <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_sram_rw_port_ctrl.sv
module tb_sram_rw_port_ctrl;

    localparam int ADDR_W = 9;
    localparam int LANES  = 8;
    localparam int LANE_W = 19;
    localparam int DW     = LANES * LANE_W;
    localparam int DEPTH  = 1 << ADDR_W;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // ---------------- DUT ----------------
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [LANES-1:0]  req_wmask;
    logic [DW-1:0]     req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [DW-1:0]     resp_data;
    logic              init_done;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_en;
    logic              mem_wmode;
    logic [LANES-1:0]  mem_wmask;
    logic [DW-1:0]     mem_wdata;
    logic [DW-1:0]     mem_rdata = '0;

    sram_rw_port_ctrl dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wmask  (req_wmask),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .init_done  (init_done),
        .mem_addr   (mem_addr),
        .mem_en     (mem_en),
        .mem_wmode  (mem_wmode),
        .mem_wmask  (mem_wmask),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    // ---------------- SRAM macro model ----------------
    function automatic logic [DW-1:0] pat(input int a);
        logic [DW-1:0] v;
        for (int l = 0; l < LANES; l++) v[l*LANE_W +: LANE_W] = LANE_W'(a * 16 + l + 256);
        return v;
    endfunction

    // Expected content of an address nobody has written since reset.
    function automatic logic [DW-1:0] exp_rd(input int a);
`ifdef SRAM_INIT_EN
        return '0;
`else
        return pat(a);
`endif
    endfunction

    logic [DW-1:0] sram [DEPTH];
    initial begin
        for (int a = 0; a < DEPTH; a++) sram[a] = pat(a);
        forever begin
            @(posedge clock);
            if (mem_en) begin
                if (mem_wmode) begin
                    for (int l = 0; l < LANES; l++)
                        if (mem_wmask[l]) sram[mem_addr][l*LANE_W +: LANE_W] = mem_wdata[l*LANE_W +: LANE_W];
                end else begin
                    mem_rdata <= sram[mem_addr];
                end
            end
        end
    end

    // ---------------- scoreboard ----------------
    int checks = 0;
    int failures = 0;
    logic [DW-1:0] exp_q[$];
    int resp_seen = 0;
    int last_resp_cyc = 0;

    task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Monitor: every accepted response is popped against the expected queue.
    initial forever begin
        @(negedge clock);
        if (reset_n && resp_valid && resp_ready) begin
            resp_seen++;
            last_resp_cyc = cyc;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_resp got=%h exp=none", resp_data);
            end else begin
                check("resp_data", resp_data, exp_q.pop_front());
            end
        end
    end

    // ---------------- driver ----------------
    // Called at posedge+1; returns at posedge+1 after the fire edge.
    task automatic do_cmd(input logic wr, input int addr, input logic [LANES-1:0] mask,
                          input logic [DW-1:0] data, input logic [DW-1:0] exp, output int fcyc);
        bit got;
        got = 0;
        fcyc = -1;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = ADDR_W'(addr);
        req_wmask = mask;
        req_wdata = data;
        for (int n = 0; n < 2000; n++) begin
            @(negedge clock);
            if (req_ready) begin
                got = 1;
                break;
            end
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL req_ready_timeout got=0 exp=1 addr=%0h", addr);
        end else begin
            check("mem_en", mem_en, 1);
            check("mem_wmode", mem_wmode, wr);
            check("mem_addr", mem_addr, addr);
            fcyc = cyc;
            if (!wr) exp_q.push_back(exp);
            @(posedge clock);
            #1;
        end
        req_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        repeat (2) @(negedge clock);
        for (int n = 0; n < 50 && exp_q.size() != 0; n++) @(negedge clock);
        @(negedge clock);
        check(name, exp_q.size(), 0);
        @(posedge clock);
        #1;
    endtask

    task automatic wait_init();
        for (int n = 0; n < 1000 && !init_done; n++) @(negedge clock);
        check("init_done_wait", init_done, 1);
        @(posedge clock);
        #1;
    endtask

    // ---------------- stimulus ----------------
    logic [DW-1:0] d1, d2, d_mix;
    int fc, first_fc, last_fc, seen0;

    initial begin
        d1    = {8{19'h2A5A5}};
        d2    = {8{19'h13C3C}};
        d_mix = {{4{19'h2A5A5}}, {4{19'h13C3C}}};
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wmask = '0; req_wdata = '0;
        resp_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clock);
        check("rst_resp_valid", resp_valid, 0);
`ifdef SRAM_INIT_EN
        check("rst_init_done", init_done, 0);
        check("rst_req_ready", req_ready, 0);
`else
        check("rst_init_done", init_done, 1);
        check("rst_req_ready", req_ready, 1);
        check("rst_mem_en", mem_en, 0);
        check("rst_mem_wmode", mem_wmode, 0);
`endif
        @(posedge clock);
        #1 reset_n = 1'b1;

`ifdef SRAM_INIT_EN
        // Scrub: 512 zero writes with full mask, commands held off.
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clock);
            check("scrub_ctrl", {mem_en, mem_wmode, mem_wmask}, {1'b1, 1'b1, 8'hFF});
            check("scrub_wdata", mem_wdata, 0);
            check("scrub_addr", mem_addr, i);
            check("scrub_hold", {init_done, req_ready}, 0);
        end
        @(negedge clock);
        check("init_done_after_scrub", init_done, 1);
        @(posedge clock);
        #1;
        do_cmd(0, 'h1FF, 0, 0, 0, fc);
        wait_drain("drain_scrub");
`endif

        // Idle port
        @(negedge clock);
        check("idle_mem_en", mem_en, 0);
        @(posedge clock);
        #1;

        // Full-throughput stream: 100 reads, no gaps in issue or response.
        seen0 = resp_seen;
        first_fc = 0;
        last_fc = 0;
        for (int a = 0; a < 100; a++) begin
            do_cmd(0, a, 0, 0, exp_rd(a), fc);
            if (a == 0) first_fc = fc;
            last_fc = fc;
        end
        wait_drain("drain_stream");
        check("stream_issue_span", last_fc - first_fc, 99);
        check("stream_resp_count", resp_seen - seen0, 100);
        check("stream_last_resp", last_resp_cyc - last_fc, 2);

        // Write then read next cycle; latency 2 with empty queue.
        do_cmd(1, 'h05, 8'hFF, d1, 0, fc);
        do_cmd(0, 'h05, 0, 0, d1, fc);
        @(negedge clock);
        check("lat_t1_resp_valid", resp_valid, 0);
        @(negedge clock);
        check("lat_t2_resp_valid", resp_valid, 1);
        @(posedge clock);
        #1;
        wait_drain("drain_lat");

        // Masked writes, plus a zero-mask write that must not change data.
        do_cmd(1, 'h10, 8'hFF, d1, 0, fc);
        do_cmd(1, 'h10, 8'h0F, d2, 0, fc);
        do_cmd(1, 'h10, 8'h00, {DW{1'b1}}, 0, fc);
        do_cmd(0, 'h10, 0, 0, d_mix, fc);
        wait_drain("drain_mask");

        // Back-pressure: 3 reads fill the reservation, 4th waits.
        resp_ready = 1'b0;
        do_cmd(0, 'h20, 0, 0, exp_rd('h20), fc);
        do_cmd(0, 'h21, 0, 0, exp_rd('h21), fc);
        do_cmd(0, 'h22, 0, 0, exp_rd('h22), fc);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 'h23;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check("bp_req_ready_low", req_ready, 0);
            check("bp_resp_valid", resp_valid, 1);
        end
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        resp_ready = 1'b1;
        do_cmd(0, 'h23, 0, 0, exp_rd('h23), fc);
        wait_drain("drain_bp");

        // Reset with 2 reads queued and 1 in flight: all discarded.
        resp_ready = 1'b0;
        do_cmd(0, 'h30, 0, 0, exp_rd('h30), fc);
        do_cmd(0, 'h31, 0, 0, exp_rd('h31), fc);
        do_cmd(0, 'h32, 0, 0, exp_rd('h32), fc);
        reset_n = 1'b0;
        exp_q.delete();
        seen0 = resp_seen;
        @(negedge clock);
        check("midrst_resp_valid", resp_valid, 0);
        @(posedge clock);
        #1;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        resp_ready = 1'b1;
        wait_init();
        repeat (8) @(negedge clock);
        check("midrst_no_stale", resp_seen - seen0, 0);
        @(posedge clock);
        #1;
        do_cmd(0, 'h40, 0, 0, exp_rd('h40), fc);
        wait_drain("drain_after_rst");

        check("final_queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

endmodule
